// File: rtl/packet_assembler.sv
// packet_assembler: reassembles NoC flits into packets across concurrent contexts and queues
// completed packets in a show-ahead FIFO for the core.
module packet_assembler #(
    parameter int NODE_COUNT      = 8,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int PAYLOAD         = 32,
    parameter int FLIT_PAYLOAD    = 8,
    parameter int CONTEXTS        = 4,
    parameter int OUT_DEPTH       = 4,
    localparam int SRC_W          = $clog2(NODE_COUNT),
    localparam int FLIT_COUNT     = (PAYLOAD + FLIT_PAYLOAD - 1) / FLIT_PAYLOAD,
    localparam int IDX_W          = FLIT_COUNT > 1 ? $clog2(FLIT_COUNT) : 1,
    localparam int FLIT_W         = 1 + SRC_W + FLIT_PAYLOAD + PACKET_ID_WIDTH + SRC_W + IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [FLIT_W-1:0]          flit_in,
    input  logic                       flit_valid,
    output logic                       flit_ready,
    output logic [PAYLOAD-1:0]         packet_out,
    output logic [SRC_W-1:0]           src_out,
    output logic [PACKET_ID_WIDTH-1:0] id_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic                       drop
);
    localparam int CTX_W = CONTEXTS > 1 ? $clog2(CONTEXTS) : 1;
    localparam int PTR_W = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int BUF_W = FLIT_COUNT * FLIT_PAYLOAD;

    typedef enum logic [1:0] {FREE, FILL, DONE} ctx_state_t;

    ctx_state_t                 state_q [CONTEXTS];
    ctx_state_t                 state_d [CONTEXTS];
    logic [FLIT_COUNT-1:0]      mask_q  [CONTEXTS];
    logic [BUF_W-1:0]           data_q  [CONTEXTS];
    logic [SRC_W-1:0]           src_q   [CONTEXTS];
    logic [PACKET_ID_WIDTH-1:0] id_q    [CONTEXTS];

    logic [PAYLOAD-1:0]         fifo_pkt [OUT_DEPTH];
    logic [SRC_W-1:0]           fifo_src [OUT_DEPTH];
    logic [PACKET_ID_WIDTH-1:0] fifo_id  [OUT_DEPTH];
    logic [PTR_W-1:0]           rd_ptr, wr_ptr;
    logic [CNT_W-1:0]           count;

    logic                       f_valid;
    logic [IDX_W-1:0]           f_idx;
    logic [SRC_W-1:0]           f_src;
    logic [PACKET_ID_WIDTH-1:0] f_id;
    logic [FLIT_PAYLOAD-1:0]    f_data;
    logic                       unused_dest;

    logic                       any_free, any_done, hit;
    logic [CTX_W-1:0]           free_sel, done_sel, hit_sel, tgt;
    logic                       accept, bad, dup, discard, write, push, pop;
    logic [FLIT_COUNT-1:0]      new_mask;

    assign f_valid     = flit_in[FLIT_W-1];
    assign f_idx       = flit_in[IDX_W-1:0];
    assign f_src       = flit_in[IDX_W +: SRC_W];
    assign f_id        = flit_in[IDX_W+SRC_W +: PACKET_ID_WIDTH];
    assign f_data      = flit_in[IDX_W+SRC_W+PACKET_ID_WIDTH +: FLIT_PAYLOAD];
    assign unused_dest = ^flit_in[FLIT_W-2 -: SRC_W];

    // descending scan so the lowest matching index wins
    always_comb begin
        any_free = 1'b0;
        free_sel = '0;
        any_done = 1'b0;
        done_sel = '0;
        hit      = 1'b0;
        hit_sel  = '0;
        for (int i = CONTEXTS - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free = 1'b1;
                free_sel = CTX_W'(i);
            end
            if (state_q[i] == DONE) begin
                any_done = 1'b1;
                done_sel = CTX_W'(i);
            end
            if (state_q[i] == FILL && src_q[i] == f_src && id_q[i] == f_id) begin
                hit     = 1'b1;
                hit_sel = CTX_W'(i);
            end
        end
    end

    assign flit_ready = ce & ~rst & any_free;
    assign accept     = flit_valid & flit_ready;
    assign bad        = ~f_valid | (int'(f_idx) >= FLIT_COUNT);
    assign dup        = hit & mask_q[hit_sel][f_idx];
    assign discard    = bad | dup;
    assign write      = accept & ~discard;
    assign tgt        = hit ? hit_sel : free_sel;
    assign new_mask   = (hit ? mask_q[hit_sel] : '0) | (FLIT_COUNT'(1) << f_idx);
    assign valid_out  = count != '0;
    assign push       = ce & any_done & (count != CNT_W'(OUT_DEPTH));
    assign pop        = ce & valid_out & ready_in;

    always_comb begin
        state_d = state_q;
        if (push) state_d[done_sel] = FREE;
        if (write) state_d[tgt] = &new_mask ? DONE : FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CONTEXTS; i++) begin
                state_q[i] <= FREE;
                mask_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (write) mask_q[tgt] <= new_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (write) begin
            data_q[tgt][f_idx*FLIT_PAYLOAD +: FLIT_PAYLOAD] <= f_data;
            src_q[tgt] <= f_src;
            id_q[tgt]  <= f_id;
        end
        if (push) begin
            fifo_pkt[wr_ptr] <= data_q[done_sel][PAYLOAD-1:0];
            fifo_src[wr_ptr] <= src_q[done_sel];
            fifo_id[wr_ptr]  <= id_q[done_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= accept & discard;
            if (push) wr_ptr <= wr_ptr == PTR_W'(OUT_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PTR_W'(OUT_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign packet_out = valid_out ? fifo_pkt[rd_ptr] : '0;
    assign src_out    = valid_out ? fifo_src[rd_ptr] : '0;
    assign id_out     = valid_out ? fifo_id[rd_ptr] : '0;
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: directed scenarios plus randomized traffic checked against a
// packet-level reference model of the reassembler.
module tb_packet_assembler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [21:0] flit_in = '0;
    logic        flit_valid = 1'b0;
    logic        flit_ready;
    logic [31:0] packet_out;
    logic [2:0]  src_out;
    logic [4:0]  id_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        drop;

    int checks = 0;
    int errors = 0;

    packet_assembler dut (
        .clk(clk), .rst(rst), .ce(ce), .flit_in(flit_in), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .packet_out(packet_out), .src_out(src_out), .id_out(id_out),
        .valid_out(valid_out), .ready_in(ready_in), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {bit [31:0] pkt; bit [2:0] src; bit [4:0] id;} pkt_t;
    typedef struct {int st; bit [2:0] src; bit [4:0] id; bit [3:0] mask; bit [31:0] data;} ctx_t;
    ctx_t mc[4];
    pkt_t mq[$];
    bit   m_drop;

    function automatic bit model_ready();
        if (rst || !ce) return 1'b0;
        foreach (mc[i]) if (mc[i].st == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic pkt_t model_head();
        pkt_t z = '0;
        return mq.size() > 0 ? mq[0] : z;
    endfunction

    // slot states: 0 free, 1 filling, 2 complete
    task automatic model_edge();
        int d = -1;
        int t = -1;
        bit acc, do_push, do_pop;
        bit disc = 1'b0;
        pkt_t p = '0;
        bit [1:0] idx = flit_in[1:0];
        bit [2:0] src = flit_in[4:2];
        bit [4:0] id = flit_in[9:5];
        bit [7:0] data = flit_in[17:10];
        if (rst) begin
            foreach (mc[i]) mc[i] = '{0, 0, 0, 0, 0};
            mq.delete();
            m_drop = 1'b0;
            return;
        end
        acc = flit_valid && model_ready();
        for (int i = 3; i >= 0; i--) if (mc[i].st == 2) d = i;
        do_push = ce && d >= 0 && mq.size() < 4;
        do_pop = ce && mq.size() > 0 && ready_in;
        if (do_push) p = '{mc[d].data, mc[d].src, mc[d].id};
        if (acc) begin
            if (!flit_in[21]) disc = 1'b1;
            else begin
                for (int i = 3; i >= 0; i--) if (mc[i].st == 1 && mc[i].src == src && mc[i].id == id) t = i;
                if (t >= 0 && mc[t].mask[idx]) disc = 1'b1;
                else begin
                    if (t < 0) begin
                        for (int i = 3; i >= 0; i--) if (mc[i].st == 0) t = i;
                        mc[t] = '{1, src, id, 0, 0};
                    end
                    mc[t].data[idx*8 +: 8] = data;
                    mc[t].mask[idx] = 1'b1;
                    if (mc[t].mask == 4'hF) mc[t].st = 2;
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(p);
            mc[d].st = 0;
        end
        m_drop = acc && disc;
    endtask

    function automatic logic [21:0] mk(bit v, bit [2:0] src, bit [4:0] id, bit [1:0] idx, bit [7:0] data);
        bit [2:0] dest = 3'($urandom);
        return {v, dest, data, id, src, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(bit [2:0] src, bit [4:0] id, bit [1:0] idx, bit [7:0] data);
        int n = 0;
        flit_in = mk(1'b1, src, id, idx, data);
        flit_valid = 1'b1;
        #1;
        while (!flit_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            errors++;
            $display("FAIL send_timeout flit_ready stayed %0b, need 1", flit_ready);
        end
        checks++;
        tick();
        flit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 7;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_out); end
        if (packet_out !== 32'h0) begin errors++; $display("FAIL reset_packet got %h exp 0", packet_out); end
        if (src_out !== 3'h0) begin errors++; $display("FAIL reset_src got %h exp 0", src_out); end
        if (id_out !== 5'h0) begin errors++; $display("FAIL reset_id got %h exp 0", id_out); end
        if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b exp 0", drop); end
        if (flit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", flit_ready); end
        rst = 1'b0;
        #1;
        if (flit_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", flit_ready); end
    endtask

    task automatic test_in_order();
        ready_in = 1'b1;
        send(2, 5, 0, 8'h11);
        send(2, 5, 1, 8'h22);
        send(2, 5, 2, 8'h33);
        send(2, 5, 3, 8'h44);
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL in_order_early_valid got %0b exp 0", valid_out); end
        tick();
        checks += 4;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL in_order_valid got %0b exp 1", valid_out); end
        if (packet_out !== 32'h44332211) begin errors++; $display("FAIL in_order_packet got %h exp 44332211", packet_out); end
        if (src_out !== 3'd2) begin errors++; $display("FAIL in_order_src got %0d exp 2", src_out); end
        if (id_out !== 5'd5) begin errors++; $display("FAIL in_order_id got %0d exp 5", id_out); end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL in_order_one_cycle got %0b exp 0", valid_out); end
    endtask

    task automatic test_out_of_order();
        send(2, 5, 3, 8'hDD);
        send(2, 5, 1, 8'hBB);
        send(2, 5, 0, 8'hAA);
        send(2, 5, 2, 8'hCC);
        tick();
        checks += 2;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL ooo_valid got %0b exp 1", valid_out); end
        if (packet_out !== 32'hDDCCBBAA) begin errors++; $display("FAIL ooo_packet got %h exp DDCCBBAA", packet_out); end
        tick();
    endtask

    task automatic test_interleave();
        bit [31:0] pa = $urandom;
        bit [31:0] pb = $urandom;
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1, 0, 2'(i), pa[i*8 +: 8]);
            seen |= drop;
            send(3, 0, 2'(i), pb[i*8 +: 8]);
            seen |= drop;
        end
        checks += 3;
        if (seen !== 1'b0) begin errors++; $display("FAIL interleave_drop got %0b exp 0", seen); end
        if (packet_out !== pa) begin errors++; $display("FAIL interleave_first got %h exp %h", packet_out, pa); end
        if (src_out !== 3'd1) begin errors++; $display("FAIL interleave_first_src got %0d exp 1", src_out); end
        tick();
        checks += 2;
        if (packet_out !== pb) begin errors++; $display("FAIL interleave_second got %h exp %h", packet_out, pb); end
        if (src_out !== 3'd3) begin errors++; $display("FAIL interleave_second_src got %0d exp 3", src_out); end
        tick();
    endtask

    task automatic test_resend();
        send(2, 5, 0, 8'h11);
        send(2, 5, 1, 8'h22);
        send(2, 5, 1, 8'hFF);
        checks++;
        if (drop !== 1'b1) begin errors++; $display("FAIL resend_drop got %0b exp 1", drop); end
        send(2, 5, 2, 8'h33);
        checks++;
        if (drop !== 1'b0) begin errors++; $display("FAIL resend_drop_width got %0b exp 0", drop); end
        send(2, 5, 3, 8'h44);
        tick();
        checks++;
        if (packet_out !== 32'h44332211) begin errors++; $display("FAIL resend_packet got %h exp 44332211", packet_out); end
        tick();
    endtask

    task automatic test_backpressure();
        bit [31:0] exp_pkt[8];
        int k = 0;
        int idx = 1;
        int n = 0;
        bit acc;
        ready_in = 1'b0;
        foreach (exp_pkt[p]) exp_pkt[p] = $urandom;
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 4; i++) send(4, 5'(8 + p), 2'(i), exp_pkt[p][i*8 +: 8]);
        send(4, 15, 0, exp_pkt[7][7:0]);
        flit_in = mk(1'b1, 4, 15, 1, exp_pkt[7][15:8]);
        flit_valid = 1'b1;
        #1;
        checks += 2;
        if (flit_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", flit_ready); end
        if (packet_out !== exp_pkt[0]) begin errors++; $display("FAIL full_head got %h exp %h", packet_out, exp_pkt[0]); end
        tick();
        tick();
        ready_in = 1'b1;
        while (k < 8 && n < 80) begin
            flit_valid = idx < 4;
            if (idx < 4) flit_in = mk(1'b1, 4, 15, 2'(idx), exp_pkt[7][idx*8 +: 8]);
            #1;
            if (valid_out) begin
                checks += 2;
                if (id_out !== 5'(8 + k)) begin errors++; $display("FAIL drain_id got %0d exp %0d", id_out, 8 + k); end
                if (packet_out !== exp_pkt[k]) begin errors++; $display("FAIL drain_packet got %h exp %h", packet_out, exp_pkt[k]); end
                k++;
            end
            acc = flit_valid && flit_ready;
            tick();
            if (acc) idx++;
            n++;
        end
        flit_valid = 1'b0;
        #1;
        checks += 2;
        if (k != 8) begin errors++; $display("FAIL drain_count got %0d exp 8", k); end
        if (flit_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %0b exp 1", flit_ready); end
    endtask

    task automatic test_reset_mid();
        bit [31:0] pn = $urandom;
        ready_in = 1'b0;
        for (int i = 0; i < 4; i++) send(5, 1, 2'(i), 8'(i + 1));
        send(6, 9, 0, 8'hA5);
        send(6, 9, 1, 8'h5A);
        checks++;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0b exp 1", valid_out); end
        rst = 1'b1;
        #1;
        checks++;
        if (flit_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %0b exp 0", flit_ready); end
        tick();
        checks += 5;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b exp 0", valid_out); end
        if (packet_out !== 32'h0) begin errors++; $display("FAIL mid_reset_packet got %h exp 0", packet_out); end
        if (src_out !== 3'h0) begin errors++; $display("FAIL mid_reset_src got %h exp 0", src_out); end
        if (id_out !== 5'h0) begin errors++; $display("FAIL mid_reset_id got %h exp 0", id_out); end
        if (drop !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got %0b exp 0", drop); end
        rst = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) send(6, 9, 2'(i), pn[i*8 +: 8]);
        tick();
        checks += 3;
        if (valid_out !== 1'b1) begin errors++; $display("FAIL new_valid got %0b exp 1", valid_out); end
        if (packet_out !== pn) begin errors++; $display("FAIL new_packet got %h exp %h", packet_out, pn); end
        if (src_out !== 3'd6) begin errors++; $display("FAIL new_src got %0d exp 6", src_out); end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL new_only got %0b exp 0", valid_out); end
    endtask

    task automatic test_random();
        pkt_t h;
        int k;
        for (int c = 0; c < 2000; c++) begin
            rst = $urandom_range(0, 299) == 0;
            ce = $urandom_range(0, 9) != 0;
            ready_in = $urandom_range(0, 9) < 7;
            flit_valid = $urandom_range(0, 9) < 7;
            k = $urandom_range(0, 2);
            flit_in = mk($urandom_range(0, 15) != 0, 3'(2 * k + 1), 5'(k + 3), 2'($urandom), 8'($urandom));
            #1;
            checks++;
            if (flit_ready !== model_ready()) begin errors++; $display("FAIL rand_ready cycle %0d got %0b exp %0b", c, flit_ready, model_ready()); end
            tick();
            h = model_head();
            checks += 5;
            if (valid_out !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid cycle %0d got %0b exp %0b", c, valid_out, mq.size() > 0); end
            if (packet_out !== h.pkt) begin errors++; $display("FAIL rand_packet cycle %0d got %h exp %h", c, packet_out, h.pkt); end
            if (src_out !== h.src) begin errors++; $display("FAIL rand_src cycle %0d got %0d exp %0d", c, src_out, h.src); end
            if (id_out !== h.id) begin errors++; $display("FAIL rand_id cycle %0d got %0d exp %0d", c, id_out, h.id); end
            if (drop !== m_drop) begin errors++; $display("FAIL rand_drop cycle %0d got %0b exp %0b", c, drop, m_drop); end
        end
        rst = 1'b0;
        ce = 1'b1;
        flit_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_interleave();
        test_resend();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
